// File: rtl/std_sram_singleport_ctrl_pkg.sv
// Shared helpers for the single-port SRAM controller and its response buffer.
package std_sram_singleport_ctrl_pkg;

   function automatic int f_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/std_sram_singleport_resp_fifo.sv
// Read-response FIFO: power-of-two depth, wrapping pointers, occupancy count.
module std_sram_singleport_resp_fifo
   import std_sram_singleport_ctrl_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   localparam int PTR_W = f_ptr_w(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_wdata;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(i_push && o_full));

endmodule

// File: rtl/std_sram_singleport_ctrl.sv
// Valid/ready request channel to single-port SRAM cycles; read data returned in order
// through a credit-guarded response FIFO.
module std_sram_singleport_ctrl
   import std_sram_singleport_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter int TAG_WIDTH  = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic [TAG_WIDTH-1:0]  resp_tag,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   localparam int PTR_W = f_ptr_w(RESP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = DATA_WIDTH + TAG_WIDTH;

   logic                 r_inflight;
   logic [TAG_WIDTH-1:0] r_tag_p1;
   logic                 w_fire;
   logic                 w_rd_fire;
   logic                 w_credit;
   logic                 w_full;
   logic                 w_empty;
   logic [CNT_W-1:0]     w_occ;
   logic [ENT_W-1:0]     w_head;

   // Credit counts the read already at the SRAM so its push can never overflow the buffer.
   assign w_credit  = ({1'b0, w_occ} + {{CNT_W{1'b0}}, r_inflight}) < (CNT_W+1)'(RESP_DEPTH);
   assign req_ready = resetn & w_credit & ~w_full;

   assign w_fire    = req_valid & req_ready;
   assign w_rd_fire = w_fire & ~req_we;

   assign sram_en   = w_fire;
   assign sram_we   = w_fire & req_we;
   assign sram_addr = req_addr;
   assign sram_din  = req_wdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_inflight <= 1'b0;
      else         r_inflight <= w_rd_fire;
   end

   // Tag rides alongside the SRAM read so it meets sram_dout one cycle later.
   always_ff @(posedge clk) begin
      if (w_rd_fire) r_tag_p1 <= req_tag;
   end

   std_sram_singleport_resp_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (r_inflight),
      .i_wdata ({sram_dout, r_tag_p1}),
      .i_pop   (resp_ready),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_occ)
   );

   assign resp_valid = ~w_empty;
   assign resp_rdata = w_head[ENT_W-1:TAG_WIDTH];
   assign resp_tag   = w_head[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_std_sram_singleport_ctrl.sv
// Directed and randomized bench for std_sram_singleport_ctrl with a behavioural SRAM.
module tb_std_sram_singleport_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int TW    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [TW-1:0] req_tag;
   logic          resp_valid, resp_ready;
   logic [DW-1:0] resp_rdata;
   logic [TW-1:0] resp_tag;
   logic          sram_en, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;

   logic [DW-1:0] mem     [16];
   logic [DW-1:0] ref_mem [16];
   int checks   = 0;
   int failures = 0;

   std_sram_singleport_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TW),
      .RESP_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_tag   (resp_tag),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   always #5 clk = ~clk;

   // Single-port SRAM: write or read per enabled cycle, read data valid next cycle.
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) mem[sram_addr] <= sram_din;
         else         sram_dout      <= mem[sram_addr];
      end
   end

   task automatic drive_idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_tag   = '0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive_idle();
      req_valid  = 1'b1;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
      end
      checks++;
      if (sram_en !== 1'b0) begin
         failures++; $display("FAIL reset_sram_en: got %b want 0", sram_en);
      end
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
      end
      req_valid = 1'b0;
      resetn    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL release_req_ready: got %b want 1", req_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
      @(negedge clk);
      checks++;
      if ({sram_en, sram_we, sram_addr, sram_din} !== {1'b1, 1'b1, 4'd3, 8'hA5}) begin
         failures++;
         $display("FAIL write_port: got en=%b we=%b addr=%h din=%h want 1 1 3 a5",
                  sram_en, sram_we, sram_addr, sram_din);
      end
      ref_mem[3] = 8'hA5;
      @(posedge clk); #1;
      req_we = 1'b0; req_tag = 2'd2; resp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_ready, sram_en, sram_we} !== 3'b110) begin
         failures++;
         $display("FAIL read_port: got ready=%b en=%b we=%b want 1 1 0", req_ready, sram_en, sram_we);
      end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++; $display("FAIL rd_latency_early: got resp_valid=%b want 0", resp_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_rdata, resp_tag} !== {1'b1, 8'hA5, 2'd2}) begin
         failures++;
         $display("FAIL raw_read: got v=%b data=%h tag=%0d want 1 a5 2", resp_valid, resp_rdata, resp_tag);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++; $display("FAIL raw_pop: got resp_valid=%b want 0", resp_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int issued = 0;
      int got = 0;
      int first_cyc = -1;
      int last_cyc = -1;
      bit ready_drop = 1'b0;
      resp_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (issued < 8) begin
            req_valid = 1'b1; req_we = 1'b0;
            req_addr = AW'(issued); req_tag = TW'(issued);
         end else begin
            drive_idle();
         end
         @(negedge clk);
         if (req_valid && !req_ready) ready_drop = 1'b1;
         if (resp_valid) begin
            checks++;
            if (got >= 8) begin
               failures++; $display("FAIL b2b_extra: got data=%h tag=%0d want none", resp_rdata, resp_tag);
            end else if ({resp_rdata, resp_tag} !== {ref_mem[got], TW'(got)}) begin
               failures++;
               $display("FAIL b2b_data[%0d]: got %h/%0d want %h/%0d", got, resp_rdata, resp_tag,
                        ref_mem[got], got % 4);
            end
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            got++;
         end
         if (req_valid && req_ready) issued++;
         @(posedge clk); #1;
      end
      checks++;
      if (ready_drop !== 1'b0) begin
         failures++; $display("FAIL b2b_ready_drop: got 1 want 0");
      end
      checks++;
      if (got != 8 || (last_cyc - first_cyc) != 7) begin
         failures++; $display("FAIL b2b_rate: got %0d responses over %0d cycles want 8 over 7",
                              got, last_cyc - first_cyc);
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      logic [DW+TW-1:0] held = '0;
      resp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         req_valid = 1'b1; req_we = 1'b0;
         req_addr = AW'(8 + acc); req_tag = TW'(acc);
         @(negedge clk);
         if (req_ready) acc++;
         if (c == 4) held = {resp_rdata, resp_tag};
         @(posedge clk); #1;
      end
      checks++;
      if (acc != 4) begin
         failures++; $display("FAIL bp_accepted: got %0d want 4", acc);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL bp_ready_low: got %b want 0", req_ready);
      end
      checks++;
      if ({resp_valid, resp_rdata, resp_tag} !== {1'b1, held} || held !== {ref_mem[8], 2'd0}) begin
         failures++;
         $display("FAIL bp_hold: got v=%b %h/%0d held %h want 1 %h/0", resp_valid, resp_rdata, resp_tag,
                  held, ref_mem[8]);
      end
      @(posedge clk); #1;
      drive_idle();
      resp_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         checks++;
         if ({resp_valid, resp_rdata, resp_tag} !== {1'b1, ref_mem[8+n], TW'(n)}) begin
            failures++;
            $display("FAIL bp_drain[%0d]: got v=%b %h/%0d want 1 %h/%0d", n, resp_valid, resp_rdata,
                     resp_tag, ref_mem[8+n], n);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         failures++; $display("FAIL bp_after: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit stale = 1'b0;
      resp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(c); req_tag = TW'(c + 1);
         @(negedge clk);
         @(posedge clk); #1;
      end
      drive_idle();
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1) begin
         failures++; $display("FAIL mid_prefill: got resp_valid=%b want 1", resp_valid);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({resp_valid, req_ready} !== 2'b00) begin
         failures++; $display("FAIL mid_reset_now: got valid=%b ready=%b want 0 0", resp_valid, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      resp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (resp_valid) stale = 1'b1;
      end
      checks++;
      if (stale !== 1'b0) begin
         failures++; $display("FAIL mid_stale: got stale response want none");
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [DW+TW-1:0] exp_q[$];
      logic [DW+TW-1:0] e;
      for (int c = 0; c < 10008; c++) begin
         if (c < 10000) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_we     = ($urandom_range(0, 2) == 0);
            req_addr   = AW'($urandom_range(0, 15));
            req_wdata  = DW'($urandom);
            req_tag    = TW'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
         end else begin
            drive_idle();
            resp_ready = 1'b1;
         end
         @(negedge clk);
         if (resp_valid && resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL rnd_unexpected: got %h/%0d want none", resp_rdata, resp_tag);
            end else begin
               e = exp_q.pop_front();
               if ({resp_rdata, resp_tag} !== e) begin
                  failures++;
                  $display("FAIL rnd_resp cyc %0d: got %h/%0d want %h/%0d", c, resp_rdata, resp_tag,
                           e[DW+TW-1:TW], e[TW-1:0]);
               end
            end
         end
         if (req_valid && req_ready) begin
            if (req_we) ref_mem[req_addr] = req_wdata;
            else        exp_q.push_back({ref_mem[req_addr], req_tag});
         end
         @(posedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL rnd_leftover: got %0d outstanding want 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]     = DW'(8'h50 + i);
         ref_mem[i] = DW'(8'h50 + i);
      end
      resp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
